fadd_share_arbiter: RTL and testbench



---
 rtl/fadd_share_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_fadd_share_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_share_arbiter.sv
// fadd_share_arbiter: two requesters share one 3-cycle pipelined single
// precision adder. Round-robin grant, credit-based issue so the adder can never
// deliver a result without a free slot, and per-requester in-order result FIFOs.
// Also contains fadd_d, the shared adder (no reset, no stall, fixed latency).

module fadd_d (
   input  logic        clk,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic [31:0] y,
   output logic        ovf
);

   logic [31:0] a_r, b_r;
   logic [31:0] y_c, y2, y3;
   logic        ovf_c, ovf2, ovf3;

   logic        sa, sb, sl, ss;
   logic [7:0]  ea, eb, el, es, d;
   logic [22:0] fa, fb;
   logic [23:0] ml, ms;
   logic [4:0]  dc, lead;
   logic [54:0] bsh;
   logic [27:0] al, bs, sum;
   logic [26:0] norm;
   logic [9:0]  exp_n, exp_r;
   logic [24:0] mant;
   logic [22:0] frac;
   logic        nan_a, nan_b, inf_a, inf_b;

   // operand capture, result alignment: three register stages in total
   always_ff @(posedge clk) begin
      a_r  <= x1;
      b_r  <= x2;
      y2   <= y_c;
      ovf2 <= ovf_c;
      y3   <= y2;
      ovf3 <= ovf2;
   end

   // IEEE add with round-to-nearest-even; denormal inputs and results flush to zero
   always_comb begin
      y_c   = '0;
      ovf_c = 1'b0;
      sa = a_r[31]; ea = a_r[30:23]; fa = a_r[22:0];
      sb = b_r[31]; eb = b_r[30:23]; fb = b_r[22:0];
      nan_a = (ea == 8'hFF) && (fa != 0);
      nan_b = (eb == 8'hFF) && (fb != 0);
      inf_a = (ea == 8'hFF) && (fa == 0);
      inf_b = (eb == 8'hFF) && (fb == 0);
      if ({ea, fa} >= {eb, fb}) begin
         sl = sa; el = ea; ml = (ea == 0) ? 24'd0 : {1'b1, fa};
         ss = sb; es = eb; ms = (eb == 0) ? 24'd0 : {1'b1, fb};
      end else begin
         sl = sb; el = eb; ml = (eb == 0) ? 24'd0 : {1'b1, fb};
         ss = sa; es = ea; ms = (ea == 0) ? 24'd0 : {1'b1, fa};
      end
      d    = el - es;
      dc   = (d > 8'd27) ? 5'd27 : d[4:0];
      bsh  = {1'b0, ms, 3'b000, 27'd0} >> dc;
      al   = {1'b0, ml, 3'b000};
      bs   = bsh[54:27] | {27'd0, |bsh[26:0]};
      sum  = (sl ^ ss) ? (al - bs) : (al + bs);
      lead = 5'd0;
      for (int k = 0; k < 28; k++) begin
         if (sum[k]) lead = 5'(k);
      end
      exp_n = {2'b00, el} + {5'd0, lead} - 10'd26;
      if (lead == 5'd27) norm = {sum[27:2], sum[1] | sum[0]};
      else               norm = sum[26:0] << (5'd26 - lead);
      mant  = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[1] | norm[0] | norm[3])};
      exp_r = mant[24] ? exp_n + 10'd1 : exp_n;
      frac  = mant[24] ? mant[23:1] : mant[22:0];
      if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
         y_c = 32'h7FC00000;
      end else if (inf_a) begin
         y_c = a_r;
      end else if (inf_b) begin
         y_c = b_r;
      end else if (sum == 0) begin
         y_c = {sl & ss, 31'd0};
      end else if (exp_n[9] || (exp_n == 0)) begin
         y_c = {sl, 31'd0};
      end else if (exp_r >= 10'd255) begin
         y_c   = {sl, 8'hFF, 23'd0};
         ovf_c = 1'b1;
      end else begin
         y_c = {sl, exp_r[7:0], frac};
      end
   end

   assign y   = y3;
   assign ovf = ovf3;

endmodule

module fadd_share_arbiter #(
   parameter int TAG_W      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [63:0]          req_x1,
   input  logic [63:0]          req_x2,
   input  logic [1:0]           req_sub,
   input  logic [2*TAG_W-1:0]   req_tag,
   output logic [1:0]           resp_valid,
   input  logic [1:0]           resp_ready,
   output logic [63:0]          resp_y,
   output logic [1:0]           resp_ovf,
   output logic [2*TAG_W-1:0]   resp_tag,
   output logic                 busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

   typedef enum logic {PRIO_R0 = 1'b0, PRIO_R1 = 1'b1} prio_t;

   prio_t             prio, prio_nxt;
   logic [1:0]        eligible, grant;
   logic              grant_any, winner;
   logic [1:0]        inflight [2];
   logic [CW:0]       used [2];
   logic [CW-1:0]     count [2];
   logic [PW-1:0]     wptr [2];
   logic [PW-1:0]     rptr [2];
   logic [2:0]        sh_v, sh_owner;
   logic [TAG_W-1:0]  sh_tag [3];
   logic [31:0]       mem_y   [2][FIFO_DEPTH];
   logic              mem_ovf [2][FIFO_DEPTH];
   logic [TAG_W-1:0]  mem_tag [2][FIFO_DEPTH];
   logic [31:0]       add_x1, add_x2, add_y;
   logic              add_ovf;
   logic [1:0]        push, pop;

   fadd_d u_fadd (
      .clk (clk),
      .x1  (add_x1),
      .x2  (add_x2),
      .y   (add_y),
      .ovf (add_ovf)
   );

   // credits come from registered occupancy only, so a same-cycle pop never helps
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         inflight[i] = 2'd0;
         for (int s = 0; s < 3; s++) begin
            if (sh_v[s] && (sh_owner[s] == 1'(i))) inflight[i] = inflight[i] + 2'd1;
         end
         used[i]     = {1'b0, count[i]} + {{(CW-1){1'b0}}, inflight[i]};
         eligible[i] = req_valid[i] && (used[i] < DEPTH_L);
      end
   end

   // round-robin pick; priority moves to the loser after every grant
   always_comb begin
      grant     = 2'b00;
      grant_any = 1'b0;
      winner    = 1'b0;
      prio_nxt  = prio;
      if (!rst) begin
         if (eligible == 2'b11) winner = (prio == PRIO_R1);
         else                   winner = eligible[1];
         grant_any = |eligible;
         if (grant_any) begin
            grant[winner] = 1'b1;
            prio_nxt      = winner ? PRIO_R0 : PRIO_R1;
         end
      end
   end

   // priority pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prio <= PRIO_R0;
      else     prio <= prio_nxt;
   end

   assign req_ready = grant;
   assign add_x1    = winner ? req_x1[63:32] : req_x1[31:0];
   assign add_x2    = (winner ? req_x2[63:32] : req_x2[31:0]) ^ {req_sub[winner], 31'd0};

   // shadow pipeline tracks which adder slots hold real work and for whom
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_v     <= 3'b000;
         sh_owner <= 3'b000;
         for (int s = 0; s < 3; s++) sh_tag[s] <= '0;
      end else begin
         sh_v      <= {sh_v[1:0], grant_any};
         sh_owner  <= {sh_owner[1:0], winner};
         sh_tag[0] <= winner ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
         sh_tag[1] <= sh_tag[0];
         sh_tag[2] <= sh_tag[1];
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         push[i] = sh_v[2] && (sh_owner[2] == 1'(i));
         pop[i]  = resp_ready[i] && (count[i] != 0);
      end
   end

   // per-requester circular result buffers; storage is cleared so heads read 0 after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            count[i] <= '0;
            wptr[i]  <= '0;
            rptr[i]  <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
               mem_y[i][j]   <= '0;
               mem_ovf[i][j] <= 1'b0;
               mem_tag[i][j] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
               mem_y[i][wptr[i]]   <= add_y;
               mem_ovf[i][wptr[i]] <= add_ovf;
               mem_tag[i][wptr[i]] <= sh_tag[2];
               wptr[i]             <= wptr[i] + PW'(1);
            end
            if (pop[i]) rptr[i] <= rptr[i] + PW'(1);
            if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
            else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
         end
      end
   end

   assign resp_valid = {count[1] != 0, count[0] != 0};
   assign resp_y     = {mem_y[1][rptr[1]], mem_y[0][rptr[0]]};
   assign resp_ovf   = {mem_ovf[1][rptr[1]], mem_ovf[0][rptr[0]]};
   assign resp_tag   = {mem_tag[1][rptr[1]], mem_tag[0][rptr[0]]};
   assign busy       = (|sh_v) || (count[0] != 0) || (count[1] != 0);

endmodule

// File: tb/tb_fadd_share_arbiter.sv
// Testbench for fadd_share_arbiter: directed scenarios plus random traffic,
// with a scoreboard fed by a transaction-level model (real-valued adds, per-port
// outstanding counts, round-robin pointer) and a negedge monitor that compares.

module tb_fadd_share_arbiter;

   localparam int TAG_W = 4;
   localparam int DEPTH = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [1:0]         req_valid = '0;
   logic [1:0]         req_ready;
   logic [63:0]        req_x1 = '0;
   logic [63:0]        req_x2 = '0;
   logic [1:0]         req_sub = '0;
   logic [2*TAG_W-1:0] req_tag = '0;
   logic [1:0]         resp_valid;
   logic [1:0]         resp_ready = '0;
   logic [63:0]        resp_y;
   logic [1:0]         resp_ovf;
   logic [2*TAG_W-1:0] resp_tag;
   logic               busy;

   fadd_share_arbiter #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x1     (req_x1),
      .req_x2     (req_x2),
      .req_sub    (req_sub),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_y     (resp_y),
      .resp_ovf   (resp_ovf),
      .resp_tag   (resp_tag),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]      y;
      logic             ovf;
      logic [TAG_W-1:0] tag;
      int               ready_at;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   int   ncyc = 0;
   exp_t expq [2][$];
   int   outst [2];
   logic prio_m;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [63:0] toDouble(input logic [31:0] f);
      if (f[30:23] == 8'd0) return {f[31], 63'd0};
      return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
   endfunction

   // reference: exact-enough double add, then round-to-nearest-even into single
   function automatic logic [32:0] refAdd(input logic [31:0] a, input logic [31:0] b, input logic sub);
      real         s;
      logic [63:0] d;
      int          e;
      logic [52:0] m;
      logic [23:0] top;
      logic [28:0] rem;
      logic [24:0] mant;
      logic        up;
      s = $bitstoreal(toDouble(a)) + $bitstoreal(toDouble(b ^ {sub, 31'd0}));
      d = $realtobits(s);
      if (d[62:0] == 63'd0) return {1'b0, d[63], 31'd0};
      e    = int'(d[62:52]) - 896;
      m    = {1'b1, d[51:0]};
      top  = m[52:29];
      rem  = m[28:0];
      up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && top[0]);
      mant = {1'b0, top} + 25'(up);
      if (mant[24]) begin
         e++;
         mant = mant >> 1;
      end
      if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
      if (e <= 0)   return {1'b0, d[63], 31'd0};
      return {1'b0, d[63], 8'(e), mant[22:0]};
   endfunction

   function automatic logic [31:0] randFloat();
      logic [7:0] e;
      e = ($urandom_range(0, 15) == 0) ? 8'd254 : 8'($urandom_range(100, 150));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // monitor: predicts grants and response presence, scores popped heads
   always @(negedge clk) begin : monitor
      logic [1:0]  elig, exp_grant, exp_valid;
      logic        win;
      logic [32:0] r;
      exp_t        e;
      if (rst) begin
         checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
         checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
         checkOutput("rst_busy", 64'(busy), 64'd0);
         checkOutput("rst_resp_y", resp_y, 64'd0);
         checkOutput("rst_resp_ovf_tag", 64'({resp_ovf, resp_tag}), 64'd0);
         expq[0].delete();
         expq[1].delete();
         outst[0] = 0;
         outst[1] = 0;
         prio_m   = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (outst[i] < DEPTH);
         exp_grant = 2'b00;
         win = (elig == 2'b11) ? prio_m : elig[1];
         if (elig != 2'b00) exp_grant[win] = 1'b1;
         checkOutput("req_ready", 64'(req_ready), 64'(exp_grant));
         checkOutput("busy", 64'(busy), 64'((outst[0] + outst[1]) > 0));
         for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("credit_overflow%0d", i), 64'(req_ready[i] && (outst[i] >= DEPTH)), 64'd0);
            exp_valid[i] = (expq[i].size() > 0) && (expq[i][0].ready_at <= ncyc);
            checkOutput($sformatf("resp_valid%0d", i), 64'(resp_valid[i]), 64'(exp_valid[i]));
            if (exp_valid[i] && resp_ready[i]) begin
               e = expq[i].pop_front();
               outst[i]--;
               if (resp_valid[i]) begin
                  checkOutput($sformatf("resp_y%0d", i), 64'(i ? resp_y[63:32] : resp_y[31:0]), 64'(e.y));
                  checkOutput($sformatf("resp_ovf%0d", i), 64'(resp_ovf[i]), 64'(e.ovf));
                  checkOutput($sformatf("resp_tag%0d", i),
                              64'(i ? resp_tag[2*TAG_W-1:TAG_W] : resp_tag[TAG_W-1:0]), 64'(e.tag));
               end
            end
         end
         if (elig != 2'b00) begin
            r = refAdd(win ? req_x1[63:32] : req_x1[31:0], win ? req_x2[63:32] : req_x2[31:0], req_sub[win]);
            e.y        = r[31:0];
            e.ovf      = r[32];
            e.tag      = win ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
            e.ready_at = ncyc + 4;
            expq[win].push_back(e);
            outst[win]++;
            prio_m = ~win;
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] v, input logic [63:0] x1, input logic [63:0] x2,
                                input logic [1:0] sub, input logic [2*TAG_W-1:0] tag, input logic [1:0] rr);
      @(posedge clk);
      #2;
      req_valid  = v;
      req_x1     = x1;
      req_x2     = x2;
      req_sub    = sub;
      req_tag    = tag;
      resp_ready = rr;
   endtask

   task automatic idleCycles(input int n, input logic [1:0] rr);
      repeat (n) applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, '0, rr);
   endtask

   task automatic expectHead(input int p, input logic [31:0] y, input logic ovf,
                             input logic [TAG_W-1:0] tag, output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!resp_valid[p] && (waited < 12));
      checkOutput($sformatf("resp_seen%0d", p), 64'(resp_valid[p]), 64'd1);
      if (resp_valid[p]) begin
         checkOutput("dir_y", 64'(p ? resp_y[63:32] : resp_y[31:0]), 64'(y));
         checkOutput("dir_ovf", 64'(resp_ovf[p]), 64'(ovf));
         checkOutput("dir_tag", 64'(p ? resp_tag[2*TAG_W-1:TAG_W] : resp_tag[TAG_W-1:0]), 64'(tag));
      end
   endtask

   initial begin : watchdog
      #1ms;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : stimulus
      int waited;
      int acc;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // single add on port 0, latency counted in negedges after the idle drive
      applyStimulus(2'b01, {32'd0, 32'h3F800000}, {32'd0, 32'h40000000}, 2'b00, 8'h05, 2'b11);
      idleCycles(1, 2'b11);
      expectHead(0, 32'h40400000, 1'b0, 4'd5, waited);
      checkOutput("add_latency", 64'(waited), 64'd4);
      idleCycles(3, 2'b11);

      // subtract and overflow on port 1
      applyStimulus(2'b10, {32'h40400000, 32'd0}, {32'h3F800000, 32'd0}, 2'b10, 8'h30, 2'b11);
      idleCycles(1, 2'b11);
      expectHead(1, 32'h40000000, 1'b0, 4'd3, waited);
      applyStimulus(2'b10, {32'h7F7FFFFF, 32'd0}, {32'h7F7FFFFF, 32'd0}, 2'b00, 8'h40, 2'b11);
      idleCycles(1, 2'b11);
      expectHead(1, 32'h7F800000, 1'b1, 4'd4, waited);
      idleCycles(3, 2'b11);

      // fairness: both ports always requesting
      for (int k = 0; k < 8; k++) begin
         applyStimulus(2'b11, {randFloat(), randFloat()}, {randFloat(), randFloat()}, 2'b00,
                       {4'(k + 8), 4'(k)}, 2'b11);
         @(negedge clk);
         checkOutput("fair_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      end
      idleCycles(8, 2'b11);

      // credit: port 0 fills without popping
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(2'b01, {32'd0, randFloat()}, {32'd0, randFloat()}, 2'b00, 8'(k), 2'b00);
         @(negedge clk);
         acc += int'(req_ready[0]);
      end
      checkOutput("credit_accepts", 64'(acc), 64'd4);
      applyStimulus(2'b11, {randFloat(), randFloat()}, {randFloat(), randFloat()}, 2'b00, 8'h99, 2'b00);
      @(negedge clk);
      checkOutput("credit_other_served", 64'(req_ready), 64'd2);
      applyStimulus(2'b01, {32'd0, randFloat()}, {32'd0, randFloat()}, 2'b00, 8'h0A, 2'b01);
      @(negedge clk);
      checkOutput("credit_pop_cycle", 64'(req_ready), 64'd0);
      applyStimulus(2'b01, {32'd0, randFloat()}, {32'd0, randFloat()}, 2'b00, 8'h0B, 2'b00);
      @(negedge clk);
      checkOutput("credit_after_pop", 64'(req_ready), 64'd1);
      applyStimulus(2'b01, {32'd0, randFloat()}, {32'd0, randFloat()}, 2'b00, 8'h0C, 2'b00);
      @(negedge clk);
      checkOutput("credit_refull", 64'(req_ready), 64'd0);
      idleCycles(14, 2'b11);

      // reset while three operations are in the adder
      for (int k = 0; k < 3; k++)
         applyStimulus(2'b01, {32'd0, 32'h3F800000}, {32'd0, 32'h3F800000}, 2'b00, 8'(k + 1), 2'b11);
      @(posedge clk);
      #2;
      rst       = 1'b1;
      req_valid = 2'b00;
      @(posedge clk);
      #2 rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("rst_flight_resp_valid", 64'(resp_valid), 64'd0);
         checkOutput("rst_flight_busy", 64'(busy), 64'd0);
      end
      applyStimulus(2'b10, {32'h3F800000, 32'd0}, {32'h3F800000, 32'd0}, 2'b00, 8'h90, 2'b11);
      idleCycles(1, 2'b11);
      expectHead(1, 32'h40000000, 1'b0, 4'd9, waited);
      idleCycles(3, 2'b11);

      // random traffic on both ports
      for (int k = 0; k < 600; k++) begin
         logic [31:0] a0, b0, a1, b1;
         a0 = randFloat();
         a1 = randFloat();
         b0 = ($urandom_range(0, 9) == 0) ? a0 : randFloat();
         b1 = ($urandom_range(0, 9) == 0) ? a1 : randFloat();
         applyStimulus({1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6)},
                       {a1, a0}, {b1, b0}, 2'($urandom), 8'($urandom),
                       {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)});
      end
      idleCycles(20, 2'b11);
      @(negedge clk);
      checkOutput("drain_empty0", 64'(expq[0].size()), 64'd0);
      checkOutput("drain_empty1", 64'(expq[1].size()), 64'd0);
      checkOutput("drain_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
